// File: rtl/clock_ctrl_pkg.sv
// Shared state encoding for the digital-clock sequencing controller.
package clock_ctrl_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] ST_RUN      = 2'd0;
  localparam logic [MODE_W-1:0] ST_SET_HOUR = 2'd1;
  localparam logic [MODE_W-1:0] ST_SET_MIN  = 2'd2;
  localparam logic [MODE_W-1:0] ST_CLEAR    = 2'd3;

  typedef enum logic [MODE_W-1:0] {
    S_RUN      = ST_RUN,
    S_SET_HOUR = ST_SET_HOUR,
    S_SET_MIN  = ST_SET_MIN,
    S_CLEAR    = ST_CLEAR
  } state_e;

endpackage

// File: rtl/clock_ctrl_key_edge.sv
// Two-flop key register with rising-edge pulse; flops reset to 1 so a key
// held through reset yields no edge until released and pressed again.
module key_edge (
  input  logic clk,
  input  logic clr,
  input  logic key,
  output logic rise
);

  logic d1_p0;
  logic d2_p1;

  always_ff @(posedge clk) begin
    if (clr) begin
      d1_p0 <= 1'b1;
      d2_p1 <= 1'b1;
    end else begin
      d1_p0 <= key;
      d2_p1 <= d1_p0;
    end
  end

  assign rise = d1_p0 & ~d2_p1;

endmodule

// File: rtl/clock_ctrl.sv
// Digital-clock sequencer: 1 Hz time base, counter enables, RUN/SET mode FSM.
// Optional macro CLOCK_CTRL_BLINK_EN adds the set-mode display blink phase.
module clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int DIV_W    = 26
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       sec_tc,
  input  logic       min_tc,
  output logic       en_sec,
  output logic       en_min,
  output logic       en_hour,
  output logic       cnt_clr_n,
  output logic       sec_clr_n,
  output logic [1:0] mode,
  output logic       tick,
  output logic       blink
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(TICK_DIV / 2 - 1);

  state_e           state, state_nxt;
  logic [DIV_W-1:0] div, div_nxt;
  logic             clr_d;
  logic             mode_rise, inc_rise;
  logic             wrap, restart;
  logic             en_sec_nxt, en_min_nxt, en_hour_nxt;
  logic             tick_nxt, cnt_clr_n_nxt, sec_clr_n_nxt;

  key_edge u_key_mode (
    .clk  (clk),
    .clr  (clr),
    .key  (key_mode),
    .rise (mode_rise)
  );

  key_edge u_key_inc (
    .clk  (clk),
    .clr  (clr),
    .key  (key_inc),
    .rise (inc_rise)
  );

  assign wrap = (div == DIV_LAST);

  always_comb begin
    state_nxt     = state;
    en_sec_nxt    = 1'b0;
    en_min_nxt    = 1'b0;
    en_hour_nxt   = 1'b0;
    cnt_clr_n_nxt = 1'b1;
    restart       = 1'b0;
    case (state)
      // clr_d marks the first cycle after clr falls: counters stay cleared once more
      S_CLEAR: begin
        if (clr_d) cnt_clr_n_nxt = 1'b0;
        else       state_nxt     = S_RUN;
      end
      S_RUN: begin
        en_sec_nxt  = wrap;
        en_min_nxt  = wrap & sec_tc;
        en_hour_nxt = wrap & sec_tc & min_tc;
        if (mode_rise) state_nxt = S_SET_HOUR;
      end
      S_SET_HOUR: begin
        if (mode_rise)     state_nxt   = S_SET_MIN;
        else if (inc_rise) en_hour_nxt = 1'b1;
      end
      S_SET_MIN: begin
        if (mode_rise) begin
          state_nxt = S_RUN;
          restart   = 1'b1;
        end else if (inc_rise) begin
          en_min_nxt = 1'b1;
        end
      end
      default: state_nxt = S_CLEAR;
    endcase

    if (state == S_CLEAR)   div_nxt = div;
    else if (restart||wrap) div_nxt = '0;
    else                    div_nxt = div + DIV_W'(1);

    tick_nxt      = wrap & ~restart & (state != S_CLEAR);
    sec_clr_n_nxt = ~restart;
  end

  // Registered outputs and control state
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= S_CLEAR;
      div       <= '0;
      clr_d     <= 1'b1;
      en_sec    <= 1'b0;
      en_min    <= 1'b0;
      en_hour   <= 1'b0;
      tick      <= 1'b0;
      cnt_clr_n <= 1'b0;
      sec_clr_n <= 1'b1;
    end else begin
      state     <= state_nxt;
      div       <= div_nxt;
      clr_d     <= 1'b0;
      en_sec    <= en_sec_nxt;
      en_min    <= en_min_nxt;
      en_hour   <= en_hour_nxt;
      tick      <= tick_nxt;
      cnt_clr_n <= cnt_clr_n_nxt;
      sec_clr_n <= sec_clr_n_nxt;
    end
  end

  assign mode = state;

`ifdef CLOCK_CTRL_BLINK_EN
  logic blink_nxt;

  // Toggle at half and full divider period -> 1 Hz, 50% duty in set states
  always_comb begin
    if (state_nxt == S_RUN || state_nxt == S_CLEAR) blink_nxt = 1'b1;
    else if (div == DIV_HALF || wrap)               blink_nxt = ~blink;
    else                                            blink_nxt = blink;
  end

  always_ff @(posedge clk) begin
    if (clr) blink <= 1'b1;
    else     blink <= blink_nxt;
  end
`else
  assign blink = 1'b1;
`endif

endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl (TICK_DIV=10): directed scenarios plus random keys,
// all outputs compared every cycle against a behavioural model.
module tb_clock_ctrl;

  localparam int TD = 10;

  logic       clk, clr, key_mode, key_inc, sec_tc, min_tc;
  logic       en_sec, en_min, en_hour, cnt_clr_n, sec_clr_n, tick, blink;
  logic [1:0] mode;

  clock_ctrl #(.TICK_DIV(TD), .DIV_W(4)) dut (
    .clk(clk), .clr(clr), .key_mode(key_mode), .key_inc(key_inc),
    .sec_tc(sec_tc), .min_tc(min_tc), .en_sec(en_sec), .en_min(en_min),
    .en_hour(en_hour), .cnt_clr_n(cnt_clr_n), .sec_clr_n(sec_clr_n),
    .mode(mode), .tick(tick), .blink(blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: mode name, phase within the second, key history
  int   m_st;
  int   m_phase;
  bit   m_fresh;
  bit   armed = 0;
  bit   kmode_hist[2];
  bit   kinc_hist[2];
  bit   x_es, x_em, x_eh, x_tick, x_cnt, x_sec, x_blink;

  always @(posedge clk) begin
    if (clr) begin
      armed = 1;
      m_st = 3; m_phase = 0; m_fresh = 1;
      kmode_hist = '{1, 1}; kinc_hist = '{1, 1};
      x_es = 0; x_em = 0; x_eh = 0; x_tick = 0;
      x_cnt = 0; x_sec = 1; x_blink = 1;
    end else if (armed) begin
      bit me, ie, sec_end, rs;
      int nst;
      me = kmode_hist[0] && !kmode_hist[1];
      ie = kinc_hist[0] && !kinc_hist[1];
      sec_end = (m_phase == TD - 1);
      nst = m_st; rs = 0;
      x_es = 0; x_em = 0; x_eh = 0; x_cnt = 1;
      if (m_st == 3) begin
        if (m_fresh) x_cnt = 0; else nst = 0;
      end else if (m_st == 0) begin
        x_es = sec_end;
        x_em = sec_end && sec_tc;
        x_eh = sec_end && sec_tc && min_tc;
        if (me) nst = 1;
      end else if (m_st == 1) begin
        if (me) nst = 2; else if (ie) x_eh = 1;
      end else begin
        if (me) begin nst = 0; rs = 1; end else if (ie) x_em = 1;
      end
      x_tick = sec_end && !rs;
      x_sec = !rs;
`ifdef CLOCK_CTRL_BLINK_EN
      if (nst == 0 || nst == 3) x_blink = 1;
      else if (m_phase == TD/2 - 1 || sec_end) x_blink = !x_blink;
`else
      x_blink = 1;
`endif
      if (m_st != 3) m_phase = rs ? 0 : (m_phase + 1) % TD;
      m_fresh = 0;
      kmode_hist[1] = kmode_hist[0]; kmode_hist[0] = key_mode;
      kinc_hist[1]  = kinc_hist[0];  kinc_hist[0]  = key_inc;
      m_st = nst;
    end
  end

  int n_tests = 0, n_fail = 0;
  int n_es, n_em, n_eh;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (armed) begin
      check("mode", mode, m_st);
      check("en_sec", en_sec, x_es);
      check("en_min", en_min, x_em);
      check("en_hour", en_hour, x_eh);
      check("tick", tick, x_tick);
      check("cnt_clr_n", cnt_clr_n, x_cnt);
      check("sec_clr_n", sec_clr_n, x_sec);
      check("blink", blink, x_blink);
    end
    n_es += en_sec; n_em += en_min; n_eh += en_hour;
  endtask

  task automatic cycles_to_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tick !== 1'b1 && n < 40);
  endtask

  task automatic press_mode();
    key_mode = 1; repeat (3) step();
    key_mode = 0; repeat (2) step();
  endtask

  task automatic press_inc();
    key_inc = 1; repeat (3) step();
    key_inc = 0; repeat (2) step();
  endtask

  int n;
  bit b0;

  initial begin
    clr = 1; key_mode = 0; key_inc = 0; sec_tc = 0; min_tc = 0;
    n_es = 0; n_em = 0; n_eh = 0;
    repeat (3) step();
    check("rst_mode", mode, 3);
    check("rst_cnt_clr_n", cnt_clr_n, 0);
    check("rst_sec_clr_n", sec_clr_n, 1);
    check("rst_blink", blink, 1);

    clr = 0;
    step();
    check("clr_extra_mode", mode, 3);
    check("clr_extra_cnt", cnt_clr_n, 0);
    step();
    check("run_mode", mode, 0);
    check("run_cnt", cnt_clr_n, 1);
    cycles_to_tick(n);
    check("first_tick", n, 10);
    check("first_en_sec", en_sec, 1);

    // Cascaded carries
    sec_tc = 1; min_tc = 1;
    cycles_to_tick(n);
    check("tick_period", n, 10);
    check("carry_min", en_min, 1);
    check("carry_hour", en_hour, 1);
    min_tc = 0;
    cycles_to_tick(n);
    check("nocarry_min", en_min, 1);
    check("nocarry_hour", en_hour, 0);
    sec_tc = 0;

    // Set hour
    press_mode();
    check("set_hour_mode", mode, 1);
    n_es = 0; n_eh = 0;
    key_inc = 1; step();
    check("inc_lat1", en_hour, 0);
    step();
    check("inc_lat2", en_hour, 1);
    key_inc = 0; repeat (3) step();
    press_inc(); press_inc();
    repeat (10) step();
    check("hour_pulses", n_eh, 3);
    check("frozen_sec", n_es, 0);

    // Set min, then exit restarts the second
    press_mode();
    check("set_min_mode", mode, 2);
    min_tc = 1; n_em = 0; n_eh = 0;
    press_inc();
    check("min_pulses", n_em, 1);
    check("min_no_hour", n_eh, 0);
    min_tc = 0;
    key_mode = 1; step(); step();
    check("exit_mode", mode, 0);
    check("exit_sec_clr", sec_clr_n, 0);
    key_mode = 0;
    cycles_to_tick(n);
    check("restart_tick", n, 10);

    // Collision: mode wins; held inc gives one pulse
    press_mode();
    n_eh = 0;
    key_mode = 1; key_inc = 1; repeat (3) step();
    key_mode = 0; key_inc = 0; repeat (2) step();
    check("collide_mode", mode, 2);
    check("collide_hour", n_eh, 0);
    n_em = 0;
    key_inc = 1; repeat (50) step();
    key_inc = 0; repeat (2) step();
    check("hold_single", n_em, 1);

    // Reset with mode key held
    key_mode = 1; clr = 1; repeat (3) step();
    clr = 0; repeat (20) step();
    check("held_rst_mode", mode, 0);
    key_mode = 0; repeat (3) step();
    check("held_rel_mode", mode, 0);
    press_mode();
    check("repress_mode", mode, 1);

`ifdef CLOCK_CTRL_BLINK_EN
    b0 = blink; n = 0;
    while (blink === b0 && n < 20) begin step(); n++; end
    b0 = blink; n = 0;
    while (blink === b0 && n < 20) begin step(); n++; end
    check("blink_half", n, 5);
`else
    check("blink_const", blink, 1);
`endif
    press_mode(); press_mode();
    check("back_run", mode, 0);
    check("run_blink", blink, 1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) key_mode = ~key_mode;
      if ($urandom_range(0, 5) == 0) key_inc = ~key_inc;
      sec_tc = 1'($urandom_range(0, 1));
      min_tc = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
- Sequencing controller for the digital-clock datapath: seconds (00-59), minutes (00-59) and hours (00-23) BCD counters.
- Generates the 1 Hz time base and the per-counter enable pulses, including cascaded carries.
- Runs a RUN / SET_HOUR / SET_MIN mode machine driven by two debounced push-keys.
- Sits between the board keys / system clock and the counter chain feeding the display driver.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per second; divider counts 0..TICK_DIV-1; minimum 4, must be even.
- DIV_W, 26, divider width; must satisfy 2^DIV_W >= TICK_DIV.

Ports:
- clk  in  1  system clock.
- clr  in  1  reset, synchronous, active-high.
- key_mode  in  1  debounced mode key, level, active-high.
- key_inc  in  1  debounced increment key, level, active-high.
- sec_tc  in  1  seconds counter currently at 59.
- min_tc  in  1  minutes counter currently at 59.
- en_sec  out  1  seconds counter enable, one-cycle pulse.
- en_min  out  1  minutes counter enable, one-cycle pulse.
- en_hour  out  1  hours counter enable, one-cycle pulse.
- cnt_clr_n  out  1  active-low clear to all three counters.
- sec_clr_n  out  1  active-low clear to the seconds counter only.
- mode  out  2  current state encoding.
- tick  out  1  1 Hz tick, one-cycle pulse.
- blink  out  1  display blank/show phase.

Behaviour:
- Single clock domain; reset is synchronous and active-high on clr. All outputs are registered.
- Reset values: en_* = 0, tick = 0, cnt_clr_n = 0, sec_clr_n = 1, mode = CLEAR, divider = 0, key sync flops = 1, blink = 1.
- Key sync flops reset to 1 so a key held through reset produces no edge until it is released and pressed again.
- Divider:
  - Increments every cycle in every state except CLEAR.
  - Wraps at TICK_DIV-1.
  - tick is high in the cycle after the divider is at TICK_DIV-1.
- Key edge detection: each key is registered twice (d1, d2); edge = d1 & ~d2. Output response appears 2 cycles after the key is first sampled high. One response per press; holding the key does not repeat.
- States: CLEAR=3, RUN=0, SET_HOUR=1, SET_MIN=2.
- CLEAR:
  - Entered on reset.
  - cnt_clr_n = 0 while clr is high and for exactly one cycle after clr falls, then the machine goes to RUN.
  - Key edges are ignored.
- RUN:
  - en_sec = divider_wrap.
  - en_min = divider_wrap & sec_tc.
  - en_hour = divider_wrap & sec_tc & min_tc.
  - All three are registered together, so they are aligned with tick.
  - A mode edge moves to SET_HOUR.
  - A key_inc edge is ignored.
- SET_HOUR:
  - en_sec and carries are forced to 0, so time is frozen.
  - A key_inc edge gives an en_hour pulse; the counter performs its own 23->00 wrap.
  - A mode edge moves to SET_MIN.
- SET_MIN:
  - Same freeze as SET_HOUR.
  - A key_inc edge gives an en_min pulse only; there is no carry into hours at 59->00.
  - A mode edge moves to RUN. On the same cycle the divider resets to 0 and sec_clr_n pulses low for one cycle, so seconds restart at 00 with a full second before the first tick.
- Simultaneous mode and inc edges in the same cycle: the mode edge wins and the inc edge is dropped.
- clr asserted in any state: next cycle is CLEAR with the reset values; any in-flight pulse is cancelled.
- At most one of en_sec / en_min / en_hour is asserted in set states; none is asserted in CLEAR.

Optional Feature:
- Macro: CLOCK_CTRL_BLINK_EN.
- Defined:
  - blink toggles when the divider is at TICK_DIV/2-1 and at TICK_DIV-1, giving a 1 Hz square wave, 50% duty.
  - blink is forced to 1 in RUN and CLEAR.
  - In SET_HOUR/SET_MIN the display blanks the field being edited while blink = 0.
- Undefined: blink is a constant 1 and no toggle logic is generated.

Decomposition:
- Package clock_ctrl_pkg:
  - State localparams ST_RUN=2'd0, ST_SET_HOUR=2'd1, ST_SET_MIN=2'd2, ST_CLEAR=2'd3.
  - MODE_W=2.
- Sub-module key_edge: two-flop register plus rising-edge pulse, reset-to-1, synchronous clr. Instantiated twice, once for key_mode and once for key_inc.

Test Plan (TICK_DIV=10):
- Reset: clr high 3 cycles then low -> cnt_clr_n low through clr plus exactly 1 cycle, mode goes 3->0, first tick 10 cycles after the divider starts, en_sec aligned with tick.
- Carry: in RUN hold sec_tc=1, min_tc=1 -> at the next tick en_sec = en_min = en_hour = 1 for one cycle; with min_tc=0 -> en_hour stays 0.
- Set hour: mode edge (mode -> 1), 3 key_inc presses -> exactly 3 en_hour pulses, each 2 cycles after its press; en_sec stays 0 across 30 cycles.
- Set min, then exit:
  - mode edge (mode -> 2), key_inc with min_tc=1 -> en_min pulse with en_hour = 0.
  - Next mode edge -> mode = 0, sec_clr_n low for one cycle, next tick exactly 10 cycles later.
- Collision and hold: key_mode and key_inc rise on the same cycle in SET_HOUR -> mode goes to 2 and no en_hour pulse. key_inc held high 50 cycles -> a single pulse.
- Reset mid-operation: key_mode held high through clr in SET_MIN -> after reset mode = 0 and no transition until the key is released and pressed again.
- Optional feature (CLOCK_CTRL_BLINK_EN defined): blink is 1 in RUN; in set states blink toggles every 5 cycles.
